// File: rtl/reg_mode_sequencer_pkg.sv
// reg_mode_pkg: select encodings shared with register4bit and the sequencer FSM states.
package reg_mode_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_COMP = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/reg_mode_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with occupancy count and synchronous flush.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_cnt;
  logic w_push, w_pop;
  assign full   = r_cnt == LW'(DEPTH);
  assign empty  = r_cnt == '0;
  assign level  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push & !full & !flush;
  assign w_pop  = pop & !empty & !flush;
  // pointers wrap naturally; r_cnt alone decides full/empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/reg_mode_sequencer.sv
// reg_mode_sequencer: queues (mode, count) commands and drives register4bit select for count cycles each.
module reg_mode_sequencer
  import reg_mode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_mode,
  input  logic [CNT_W-1:0]           cmd_count,
  input  logic                       abort,
  output logic [1:0]                 s,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  state_t r_state;
  logic [CNT_W-1:0] r_rem;
  logic [1:0] r_s;
  logic r_busy, r_done;
  logic [CNT_W+1:0] w_head;
  logic [1:0] w_head_mode;
  logic [CNT_W-1:0] w_head_cnt;
  logic w_full, w_empty, w_push, w_pop, w_last, w_chain;
  assign w_head_mode = w_head[CNT_W+1:CNT_W];
  assign w_head_cnt  = w_head[CNT_W-1:0];
  assign cmd_ready   = !w_full & !abort;
  assign w_push      = cmd_valid & cmd_ready;
  assign w_last      = r_state == RUN && r_rem == CNT_W'(1);
  // a zero-count head is not chained from RUN; IDLE retires it next cycle
  assign w_chain     = w_last & !w_empty & w_head_cnt != '0;
  assign w_pop       = !abort & ((r_state == IDLE & !w_empty) | w_chain);
  assign s           = r_s;
  assign busy        = r_busy;
  assign done        = r_done;
  cmd_fifo #(.DEPTH(DEPTH), .W(CNT_W + 2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (w_push),
    .din   ({cmd_mode, cmd_count}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_s     <= MODE_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_s     <= MODE_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (!w_empty && w_head_cnt == '0) begin
          r_done <= 1'b1;
        end else if (!w_empty) begin
          r_s     <= w_head_mode;
          r_rem   <= w_head_cnt;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
      end else if (!w_last) begin
        r_rem <= r_rem - CNT_W'(1);
      end else begin
        r_done <= 1'b1;
        if (w_chain) begin
          r_s   <= w_head_mode;
          r_rem <= w_head_cnt;
        end else begin
          r_s     <= MODE_HOLD;
          r_rem   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_mode_sequencer.sv
// tb_reg_mode_sequencer: drives command scripts and scoreboards select/register/status per cycle.
module tb_reg_mode_sequencer;
  import reg_mode_pkg::*;
  localparam logic [3:0] DATA_IN = 4'b1001;
  typedef struct packed {logic [1:0] s; logic [3:0] q; logic busy; logic done; logic [2:0] lvl;} exp_t;
  typedef struct packed {logic v; logic [1:0] m; logic [3:0] c; logic a;} stim_t;
  logic clk = 0, reset = 1, cmd_valid = 0, abort = 0, cmd_ready, busy, done;
  logic [1:0] cmd_mode = 0, s;
  logic [3:0] cmd_count = 0, q;
  logic [2:0] fifo_level;
  int checks = 0, failures = 0;
  exp_t sb[$];
  reg_mode_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .abort(abort), .s(s),
    .busy(busy), .done(done), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  // register4bit reference: rotate right/left, complement, hold; reset reloads data_in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= DATA_IN;
    else q <= s == MODE_COMP ? ~q : s == MODE_SHR ? {q[0], q[3:1]} : s == MODE_SHL ? {q[2:0], q[3]} : q;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input stim_t st);
    cmd_valid = st.v;
    cmd_mode  = st.m;
    cmd_count = st.c;
    abort     = st.a;
  endtask
  task automatic do_reset();
    drive('0);
    reset = 1;
    step();
    step();
    reset = 0;
  endtask
  task automatic test_reset();
    step();
    step();
    checks += 5;
    if (s !== 2'b00) begin failures++; $display("FAIL reset_s got=%b exp=00", s); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    if (q !== DATA_IN) begin failures++; $display("FAIL reset_q got=%b exp=%b", q, DATA_IN); end
    reset = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
  endtask
  task automatic test_shr();
    stim_t st [6] = '{'{1'b1, MODE_SHR, 4'd3, 1'b0}, '0, '0, '0, '0, '0};
    exp_t ex [6] = '{'{2'b00, 4'b1001, 1'b0, 1'b0, 3'd1}, '{2'b10, 4'b1001, 1'b1, 1'b0, 3'd0},
                     '{2'b10, 4'b1100, 1'b1, 1'b0, 3'd0}, '{2'b10, 4'b0110, 1'b1, 1'b0, 3'd0},
                     '{2'b00, 4'b0011, 1'b0, 1'b1, 3'd0}, '{2'b00, 4'b0011, 1'b0, 1'b0, 3'd0}};
    exp_t e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(st[k]);
      sb.push_back(ex[k]);
      step();
      e = sb.pop_front();
      checks += 5;
      if (s !== e.s) begin failures++; $display("FAIL shr_s[%0d] got=%b exp=%b", k, s, e.s); end
      if (q !== e.q) begin failures++; $display("FAIL shr_q[%0d] got=%b exp=%b", k, q, e.q); end
      if (busy !== e.busy) begin failures++; $display("FAIL shr_busy[%0d] got=%b exp=%b", k, busy, e.busy); end
      if (done !== e.done) begin failures++; $display("FAIL shr_done[%0d] got=%b exp=%b", k, done, e.done); end
      if (fifo_level !== e.lvl) begin failures++; $display("FAIL shr_level[%0d] got=%0d exp=%0d", k, fifo_level, e.lvl); end
    end
  endtask
  task automatic test_back_to_back();
    stim_t st [6] = '{'{1'b1, MODE_COMP, 4'd2, 1'b0}, '{1'b1, MODE_SHL, 4'd1, 1'b0}, '0, '0, '0, '0};
    exp_t ex [6] = '{'{2'b00, 4'b1001, 1'b0, 1'b0, 3'd1}, '{2'b01, 4'b1001, 1'b1, 1'b0, 3'd1},
                     '{2'b01, 4'b0110, 1'b1, 1'b0, 3'd1}, '{2'b11, 4'b1001, 1'b1, 1'b1, 3'd0},
                     '{2'b00, 4'b0011, 1'b0, 1'b1, 3'd0}, '{2'b00, 4'b0011, 1'b0, 1'b0, 3'd0}};
    exp_t e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(st[k]);
      sb.push_back(ex[k]);
      step();
      e = sb.pop_front();
      checks += 5;
      if (s !== e.s) begin failures++; $display("FAIL b2b_s[%0d] got=%b exp=%b", k, s, e.s); end
      if (q !== e.q) begin failures++; $display("FAIL b2b_q[%0d] got=%b exp=%b", k, q, e.q); end
      if (busy !== e.busy) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", k, busy, e.busy); end
      if (done !== e.done) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%b", k, done, e.done); end
      if (fifo_level !== e.lvl) begin failures++; $display("FAIL b2b_level[%0d] got=%0d exp=%0d", k, fifo_level, e.lvl); end
    end
  endtask
  task automatic test_full();
    int n = 0;
    do_reset();
    drive('{1'b1, MODE_COMP, 4'd15, 1'b0});
    step();
    drive('{1'b1, MODE_SHR, 4'd2, 1'b0});
    repeat (4) step();
    checks += 2;
    if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", cmd_ready); end
    drive('{1'b1, MODE_SHL, 4'd1, 1'b0});
    while (cmd_ready !== 1'b1 && n < 40) begin
      checks++;
      if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_hold_level got=%0d exp=4", fifo_level); end
      step();
      n++;
    end
    checks += 2;
    if (n !== 12) begin failures++; $display("FAIL full_wait_cycles got=%0d exp=12", n); end
    if (fifo_level !== 3'd3) begin failures++; $display("FAIL full_after_pop_level got=%0d exp=3", fifo_level); end
    step();
    drive('0);
    checks += 2;
    if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_refill_level got=%0d exp=4", fifo_level); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_refill_ready got=%b exp=0", cmd_ready); end
  endtask
  task automatic test_zero_count();
    stim_t st [3] = '{'{1'b1, MODE_COMP, 4'd0, 1'b0}, '0, '0};
    exp_t ex [3] = '{'{2'b00, 4'b1001, 1'b0, 1'b0, 3'd1}, '{2'b00, 4'b1001, 1'b0, 1'b1, 3'd0},
                     '{2'b00, 4'b1001, 1'b0, 1'b0, 3'd0}};
    exp_t e;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(st[k]);
      sb.push_back(ex[k]);
      step();
      e = sb.pop_front();
      checks += 5;
      if (s !== e.s) begin failures++; $display("FAIL zero_s[%0d] got=%b exp=%b", k, s, e.s); end
      if (q !== e.q) begin failures++; $display("FAIL zero_q[%0d] got=%b exp=%b", k, q, e.q); end
      if (busy !== e.busy) begin failures++; $display("FAIL zero_busy[%0d] got=%b exp=%b", k, busy, e.busy); end
      if (done !== e.done) begin failures++; $display("FAIL zero_done[%0d] got=%b exp=%b", k, done, e.done); end
      if (fifo_level !== e.lvl) begin failures++; $display("FAIL zero_level[%0d] got=%0d exp=%0d", k, fifo_level, e.lvl); end
    end
  endtask
  task automatic test_abort();
    stim_t st [7] = '{'{1'b1, MODE_SHL, 4'd10, 1'b0}, '{1'b1, MODE_COMP, 4'd3, 1'b0},
                      '{1'b1, MODE_SHR, 4'd2, 1'b0}, '0, '0, '{1'b1, MODE_COMP, 4'd1, 1'b1}, '0};
    exp_t ex [7] = '{'{2'b00, 4'b1001, 1'b0, 1'b0, 3'd1}, '{2'b11, 4'b1001, 1'b1, 1'b0, 3'd1},
                     '{2'b11, 4'b0011, 1'b1, 1'b0, 3'd2}, '{2'b11, 4'b0110, 1'b1, 1'b0, 3'd2},
                     '{2'b11, 4'b1100, 1'b1, 1'b0, 3'd2}, '{2'b00, 4'b1001, 1'b0, 1'b0, 3'd0},
                     '{2'b00, 4'b1001, 1'b0, 1'b0, 3'd0}};
    exp_t e;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(st[k]);
      sb.push_back(ex[k]);
      if (k == 5) begin
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", cmd_ready); end
      end
      step();
      e = sb.pop_front();
      checks += 5;
      if (s !== e.s) begin failures++; $display("FAIL abort_s[%0d] got=%b exp=%b", k, s, e.s); end
      if (q !== e.q) begin failures++; $display("FAIL abort_q[%0d] got=%b exp=%b", k, q, e.q); end
      if (busy !== e.busy) begin failures++; $display("FAIL abort_busy[%0d] got=%b exp=%b", k, busy, e.busy); end
      if (done !== e.done) begin failures++; $display("FAIL abort_done[%0d] got=%b exp=%b", k, done, e.done); end
      if (fifo_level !== e.lvl) begin failures++; $display("FAIL abort_level[%0d] got=%0d exp=%0d", k, fifo_level, e.lvl); end
    end
  endtask
  task automatic test_midrun_reset();
    do_reset();
    drive('{1'b1, MODE_SHR, 4'd8, 1'b0});
    step();
    drive('{1'b1, MODE_COMP, 4'd2, 1'b0});
    step();
    drive('0);
    step();
    step();
    checks++;
    if (q !== 4'b0110) begin failures++; $display("FAIL mrst_pre_q got=%b exp=0110", q); end
    #2;
    reset = 1;
    #1;
    checks += 5;
    if (s !== 2'b00) begin failures++; $display("FAIL mrst_s got=%b exp=00", s); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL mrst_done got=%b exp=0", done); end
    if (fifo_level !== 3'd0) begin failures++; $display("FAIL mrst_level got=%0d exp=0", fifo_level); end
    if (q !== DATA_IN) begin failures++; $display("FAIL mrst_q got=%b exp=%b", q, DATA_IN); end
    step();
    reset = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks += 3;
      if (s !== 2'b00) begin failures++; $display("FAIL mrst_after_s[%0d] got=%b exp=00", k, s); end
      if (busy !== 1'b0) begin failures++; $display("FAIL mrst_after_busy[%0d] got=%b exp=0", k, busy); end
      if (q !== DATA_IN) begin failures++; $display("FAIL mrst_after_q[%0d] got=%b exp=%b", k, q, DATA_IN); end
    end
  endtask
  initial begin
    test_reset();
    test_shr();
    test_back_to_back();
    test_full();
    test_zero_count();
    test_abort();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_mode_sequencer.md
Name: reg_mode_sequencer

Overview:
Upstream command stage for register4bit. Accepts (mode, repeat-count) commands over a valid/ready handshake and buffers them in a small FIFO. It then drives the register's 2-bit select so each mode is applied for exactly the requested number of clock cycles, and returns to HOLD (00) when idle. Lets software-style controllers script complement/shift sequences without cycle-exact timing.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 4, width of repeat count (max run length 2^CNT_W-1 cycles)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&ready at clk edge
cmd_mode  input  2  00 hold, 01 complement, 10 shift right, 11 shift left
cmd_count  input  CNT_W  cycles to apply cmd_mode; 0 = no-op
abort  input  1  synchronous flush of FIFO and current run
s  output  2  registered select to register4bit
busy  output  1  high while in RUN
done  output  1  one-cycle pulse per completed command (incl. zero-count)
fifo_level  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, any time incl. mid-run): s=00, busy=0, done=0, FIFO empty, fifo_level=0, state IDLE, rem=0; cmd_ready=1 once reset deasserts.
- cmd_ready = !full & !abort (combinational). Push while full is never accepted, even if a pop occurs the same edge.
- FIFO latency: command pushed at edge E is visible at the head after E; earliest pop is E+1.
- FSM states IDLE, RUN; remaining-cycle counter rem (CNT_W bits).
- IDLE, FIFO empty: s=00, hold.
- IDLE, head count=0: pop, done<=1, s stays 00, remain IDLE.
- IDLE, head count=N>0: pop, s<=mode, rem<=N, busy<=1, go RUN. register4bit samples s=mode on exactly N subsequent edges.
- RUN, rem>1: rem<=rem-1, s held.
- RUN, rem==1 (final edge): done<=1. If head present with count>0: pop, s<=head mode, rem<=head count, stay RUN (back-to-back, no 00 gap). Otherwise s<=00, busy<=0, go IDLE. A zero-count head is left for IDLE to consume next cycle.
- mode 00 with count>0 is legal: s=00 for N cycles, busy high.
- abort (highest priority after reset): at the edge, FIFO emptied, s<=00, busy<=0, rem<=0, IDLE, no done pulse. A same-cycle push is dropped; cmd_ready is low that cycle.
- done is low except on the single cycle following each command completion.
- fifo_level reflects push/pop of the same edge: simultaneous push and pop leaves it unchanged.
- No arithmetic overflow: rem only decrements from >=1; FIFO pointers are log2(DEPTH) bits and wrap naturally, with a separate count for full/empty.

Decomposition:
- Shared package reg_mode_pkg: mode constants MODE_HOLD=2'b00, MODE_COMP=2'b01, MODE_SHR=2'b10, MODE_SHL=2'b11 (also usable by register4bit); FSM state encoding IDLE/RUN.
- One sub-module: cmd_fifo (synchronous FIFO, width 2+CNT_W, depth DEPTH, push/pop/full/empty/level, async active-high reset, flush input driven by abort).
- FSM, counter and output registers live in reg_mode_sequencer.

Test Plan:
- Bench pairs the sequencer with register4bit, data_in=4'b1001. Push SHR count 3 -> s=10 for exactly 3 cycles, q: 1001->1100->0110->0011, then s=00 and q holds; one done pulse.
- Push COMP count 2, then SHL count 1 back-to-back -> s=01,01,11 with no 00 gap. q: 1001->0110->1001->0011. Two done pulses; busy high across all 3 cycles.
- Push DEPTH=4 commands with no pop possible (first is count 15) -> cmd_ready low at fifo_level=4. A 5th valid is not accepted; it is accepted on the cycle after the first pop.
- Push count 0 COMP into an idle block -> s stays 00, q unchanged, done pulses once, busy never rises.
- Mid-run abort (SHL count 10, abort after 4 cycles, queue holding 2 entries) -> next edge s=00, fifo_level=0, busy=0, no done; a push concurrent with abort is dropped.
- Assert reset mid-run of SHR count 8 -> immediately s=00, busy=0, fifo_level=0, register reloads data_in; after release no residual command executes.
